// File: rtl/axis_bcast_pkg.sv
// Shared types and constants for the N-channel AXI-Stream broadcaster.
// Optional drop statistics are enabled with AXIS_BCAST_STATS_EN.
package axis_bcast_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PASS = 2'd1,
    DROP = 2'd2,
    SKIP = 2'd3
  } ch_state_t;

  localparam logic MODE_BLOCKING = 1'b0;
  localparam logic MODE_LOSSY    = 1'b1;

  localparam int DROP_CNT_W = 16;

endpackage

// File: rtl/axis_fifo_lite.sv
// Small synchronous FIFO carrying {tlast, tdata}; output is zero while empty.
// Full/empty derive only from registered pointers, so a same-cycle read never frees a slot.
module axis_fifo_lite #(
  parameter int C_DATA_WIDTH = 32,
  parameter int C_DEPTH      = 4
) (
  input  logic                    s_axi_aclk,
  input  logic                    s_axi_aresetn,
  input  logic                    wr_en,
  input  logic [C_DATA_WIDTH-1:0] wr_data,
  input  logic                    wr_last,
  output logic                    full,
  input  logic                    rd_ready,
  output logic                    rd_valid,
  output logic [C_DATA_WIDTH-1:0] rd_data,
  output logic                    rd_last
);

  localparam int AW = $clog2(C_DEPTH);

  logic [AW:0]           wr_ptr;
  logic [AW:0]           rd_ptr;
  logic [C_DATA_WIDTH:0] mem [C_DEPTH];
  logic                  empty;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en && !full)     wr_ptr <= wr_ptr + 1'b1;
      if (rd_ready && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge s_axi_aclk) begin
    if (wr_en && !full) mem[wr_ptr[AW-1:0]] <= {wr_last, wr_data};
  end

  assign rd_valid           = !empty;
  assign {rd_last, rd_data} = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/axis_broadcaster_n.sv
// N-channel AXI-Stream broadcaster with per-channel FIFOs, enables and blocking/lossy modes.
// Define AXIS_BCAST_STATS_EN to add per-channel drop counters (o_drop_count, i_stats_clr).
module axis_broadcaster_n
  import axis_bcast_pkg::*;
#(
  parameter int C_DATA_WIDTH = 32,
  parameter int C_NUM_CH     = 2,
  parameter int C_CH_DEPTH   = 4
) (
  input  logic                             s_axi_aclk,
  input  logic                             s_axi_aresetn,
  input  logic [C_NUM_CH-1:0]              i_ch_enable,
  input  logic                             i_mode,
  output logic                             s_axis_tready,
  input  logic                             s_axis_tvalid,
  input  logic [C_DATA_WIDTH-1:0]          s_axis_tdata,
  input  logic                             s_axis_tlast,
  input  logic [C_NUM_CH-1:0]              m_axis_tready,
  output logic [C_NUM_CH-1:0]              m_axis_tvalid,
  output logic [C_NUM_CH*C_DATA_WIDTH-1:0] m_axis_tdata,
  output logic [C_NUM_CH-1:0]              m_axis_tlast
`ifdef AXIS_BCAST_STATS_EN
  ,
  input  logic                             i_stats_clr,
  output logic [C_NUM_CH*DROP_CNT_W-1:0]   o_drop_count
`endif
);

  logic                pkt_start_q;
  logic                mode_q;
  logic [C_NUM_CH-1:0] en_q;
  logic                mode_eff;
  logic [C_NUM_CH-1:0] en_eff;
  logic                acc;
  logic [C_NUM_CH-1:0] ch_stall;
  logic                core_ready;

  // On a packet-start beat the live configuration applies; afterwards the latched copy.
  assign mode_eff = pkt_start_q ? i_mode : mode_q;
  assign en_eff   = pkt_start_q ? i_ch_enable : en_q;
  assign acc      = s_axis_tvalid && s_axis_tready;

  assign core_ready    = (mode_eff == MODE_LOSSY) || (ch_stall == '0);
  assign s_axis_tready = s_axi_aresetn && core_ready;

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      pkt_start_q <= 1'b1;
      mode_q      <= MODE_BLOCKING;
      en_q        <= '0;
    end else if (acc) begin
      pkt_start_q <= s_axis_tlast;
      if (pkt_start_q) begin
        mode_q <= i_mode;
        en_q   <= i_ch_enable;
      end
    end
  end

  for (genvar i = 0; i < C_NUM_CH; i++) begin : g_ch
    ch_state_t state_q;
    ch_state_t state_d;
    logic      wr;
    logic      full;

    assign ch_stall[i] = ((state_q == PASS) || ((state_q == IDLE) && en_eff[i])) && full;

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) state_q <= IDLE;
      else                state_q <= state_d;
    end

    // A full FIFO on an accepted beat can only occur in lossy mode.
    always_comb begin
      state_d = state_q;
      wr      = 1'b0;
      if (acc) begin
        case (state_q)
          IDLE: begin
            if (!en_eff[i]) begin
              state_d = SKIP;
            end else if (!full) begin
              wr      = 1'b1;
              state_d = PASS;
            end else begin
              state_d = DROP;
            end
          end
          PASS: begin
            if (!full) wr = 1'b1;
            else       state_d = DROP;
          end
          default: ;
        endcase
        if (s_axis_tlast) state_d = IDLE;
      end
    end

    axis_fifo_lite #(
      .C_DATA_WIDTH(C_DATA_WIDTH),
      .C_DEPTH     (C_CH_DEPTH)
    ) u_fifo (
      .s_axi_aclk   (s_axi_aclk),
      .s_axi_aresetn(s_axi_aresetn),
      .wr_en        (wr),
      .wr_data      (s_axis_tdata),
      .wr_last      (s_axis_tlast),
      .full         (full),
      .rd_ready     (m_axis_tready[i]),
      .rd_valid     (m_axis_tvalid[i]),
      .rd_data      (m_axis_tdata[i*C_DATA_WIDTH +: C_DATA_WIDTH]),
      .rd_last      (m_axis_tlast[i])
    );

`ifdef AXIS_BCAST_STATS_EN
    logic                  drop_beat;
    logic [DROP_CNT_W-1:0] cnt_q;

    assign drop_beat = acc && ((state_q == DROP) ||
                       (((state_q == IDLE) && en_eff[i]) || (state_q == PASS)) && full);

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn)                  cnt_q <= '0;
      else if (i_stats_clr)                cnt_q <= '0;
      else if (drop_beat && (cnt_q != '1)) cnt_q <= cnt_q + 1'b1;
    end

    assign o_drop_count[i*DROP_CNT_W +: DROP_CNT_W] = cnt_q;
`endif
  end

endmodule

// File: tb/tb_axis_broadcaster_n.sv
// Randomized and directed bench for axis_broadcaster_n against a queue-based reference model.
// Drop counters are checked when AXIS_BCAST_STATS_EN is defined.
module tb_axis_broadcaster_n;
  localparam int W = 32;
  localparam int N = 4;
  localparam int D = 4;

  logic             s_axi_aclk = 1'b0;
  logic             s_axi_aresetn = 1'b0;
  logic [N-1:0]     i_ch_enable = '0;
  logic             i_mode = 1'b0;
  logic             s_axis_tready;
  logic             s_axis_tvalid = 1'b0;
  logic [W-1:0]     s_axis_tdata = '0;
  logic             s_axis_tlast = 1'b0;
  logic [N-1:0]     m_axis_tready = '0;
  logic [N-1:0]     m_axis_tvalid;
  logic [N*W-1:0]   m_axis_tdata;
  logic [N-1:0]     m_axis_tlast;
`ifdef AXIS_BCAST_STATS_EN
  logic             i_stats_clr = 1'b0;
  logic [N*16-1:0]  o_drop_count;
`endif

  always #5 s_axi_aclk = ~s_axi_aclk;

  axis_broadcaster_n #(.C_DATA_WIDTH(W), .C_NUM_CH(N), .C_CH_DEPTH(D)) dut (
    .s_axi_aclk   (s_axi_aclk),
    .s_axi_aresetn(s_axi_aresetn),
    .i_ch_enable  (i_ch_enable),
    .i_mode       (i_mode),
    .s_axis_tready(s_axis_tready),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tlast (s_axis_tlast),
    .m_axis_tready(m_axis_tready),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tlast (m_axis_tlast)
`ifdef AXIS_BCAST_STATS_EN
    ,
    .i_stats_clr  (i_stats_clr),
    .o_drop_count (o_drop_count)
`endif
  );

  typedef struct {
    logic [W-1:0] data;
    logic         last;
  } beat_t;

  // Fate of the current packet on each channel: 0 = delivered, 1 = dropped, 2 = skipped.
  beat_t        src_q[$];
  beat_t        mq [N][$];
  int           fate [N];
  bit           m_start = 1'b1;
  bit           m_mode = 1'b0;
  int           m_drops [N];
  int           err_cnt = 0;
  int           chk_cnt = 0;
  int           acc_cnt = 0;
  int           rx_cnt [N];
  int           rx_last [N];
  int           vprob = 100;
  bit           rdy_rand = 1'b0;
  bit           cfg_rand = 1'b0;
  logic [N-1:0] rdy_val = '1;
  bit           acc_q = 1'b0;

  task automatic chk(string tag, logic [31:0] act, logic [31:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic bit model_ready();
    bit md;
    md = m_start ? i_mode : m_mode;
    if (md) return 1'b1;
    for (int c = 0; c < N; c++) begin
      if ((m_start ? bit'(i_ch_enable[c]) : (fate[c] == 0)) && (mq[c].size() == D)) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic sample();
    bit full [N];
    bit acc;
    bit exp_v;
    chk("s_tready", 32'(s_axis_tready), 32'(model_ready()));
    for (int c = 0; c < N; c++) begin
      exp_v = (mq[c].size() > 0);
      chk($sformatf("ch%0d_tvalid", c), 32'(m_axis_tvalid[c]), 32'(exp_v));
      if (exp_v) begin
        chk($sformatf("ch%0d_tdata", c), m_axis_tdata[c*W +: W], mq[c][0].data);
        chk($sformatf("ch%0d_tlast", c), 32'(m_axis_tlast[c]), 32'(mq[c][0].last));
      end
`ifdef AXIS_BCAST_STATS_EN
      chk($sformatf("ch%0d_drops", c), 32'(o_drop_count[c*16 +: 16]), 32'(m_drops[c]));
`endif
      full[c] = (mq[c].size() == D);
      if (exp_v && m_axis_tready[c]) begin
        rx_cnt[c]++;
        if (mq[c][0].last) rx_last[c]++;
        void'(mq[c].pop_front());
      end
    end
    acc   = s_axis_tvalid && s_axis_tready;
    acc_q = acc;
    if (acc) begin
      acc_cnt++;
      if (m_start) begin
        m_mode = i_mode;
        for (int c = 0; c < N; c++) fate[c] = i_ch_enable[c] ? 0 : 2;
      end
      for (int c = 0; c < N; c++) begin
        if (fate[c] == 0 && full[c]) fate[c] = 1;
        if (fate[c] == 0) mq[c].push_back('{s_axis_tdata, s_axis_tlast});
        if (fate[c] == 1 && m_drops[c] < 65535) m_drops[c]++;
      end
      m_start = s_axis_tlast;
      if (src_q.size() > 0) void'(src_q.pop_front());
    end
`ifdef AXIS_BCAST_STATS_EN
    if (i_stats_clr) for (int c = 0; c < N; c++) m_drops[c] = 0;
`endif
  endtask

  task automatic drive();
    m_axis_tready = rdy_rand ? N'($urandom) : rdy_val;
    if (cfg_rand) begin
      i_mode      = 1'($urandom);
      i_ch_enable = N'($urandom);
    end
    if (!(s_axis_tvalid && !acc_q)) begin
      s_axis_tvalid = (src_q.size() > 0) && (int'($urandom_range(99)) < vprob);
      if (s_axis_tvalid) begin
        s_axis_tdata = src_q[0].data;
        s_axis_tlast = src_q[0].last;
      end
    end
  endtask

  task automatic cycles(int n);
    repeat (n) begin
      @(negedge s_axi_aclk);
      sample();
      @(posedge s_axi_aclk);
      #1;
      drive();
    end
  endtask

  task automatic push(int n, logic [W-1:0] base, int last_every);
    for (int k = 0; k < n; k++)
      src_q.push_back('{base + W'(k), (last_every > 0) && ((k + 1) % last_every == 0)});
  endtask

  task automatic clear_counts();
    acc_cnt = 0;
    for (int c = 0; c < N; c++) begin
      rx_cnt[c]  = 0;
      rx_last[c] = 0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int c = 0; c < N; c++) begin
      fate[c]    = 2;
      m_drops[c] = 0;
    end
    clear_counts();
    repeat (2) @(posedge s_axi_aclk);
    #1;
    chk("rst_tready", 32'(s_axis_tready), 32'h0);
    chk("rst_tvalid", 32'(m_axis_tvalid), 32'h0);
    chk("rst_tlast", 32'(m_axis_tlast), 32'h0);
    for (int c = 0; c < N; c++) chk("rst_tdata", m_axis_tdata[c*W +: W], 32'h0);
    @(posedge s_axi_aclk);
    #3 s_axi_aresetn = 1'b1;
    #1 chk("post_rst_tready", 32'(s_axis_tready), 32'h1);

    // Blocking: ch1 stalled fills its FIFO and throttles the source after 4 beats.
    i_mode = 1'b0; i_ch_enable = 4'b0011; rdy_val = 4'b1101;
    clear_counts();
    push(8, 32'h1, 8);
    cycles(20);
    chk("blk_acc_stall", 32'(acc_cnt), 32'd4);
    chk("blk_ch0_stall", 32'(rx_cnt[0]), 32'd4);
    rdy_val = 4'b1111;
    cycles(20);
    chk("blk_acc", 32'(acc_cnt), 32'd8);
    chk("blk_ch0", 32'(rx_cnt[0]), 32'd8);
    chk("blk_ch1", 32'(rx_cnt[1]), 32'd8);
    chk("blk_ch1_last", 32'(rx_last[1]), 32'd1);

    // Lossy: ch1 stalled keeps only the first 4 beats of packet 1.
    i_mode = 1'b1; rdy_val = 4'b1101;
    clear_counts();
    push(6, 32'h10, 6); push(6, 32'h20, 6); push(6, 32'h30, 6);
    cycles(30);
    chk("lossy_acc", 32'(acc_cnt), 32'd18);
    chk("lossy_ch0", 32'(rx_cnt[0]), 32'd18);
    chk("lossy_ch1_stalled", 32'(rx_cnt[1]), 32'd0);
`ifdef AXIS_BCAST_STATS_EN
    chk("lossy_ch1_drops", 32'(o_drop_count[31:16]), 32'd14);
`endif
    rdy_val = 4'b1111;
    cycles(10);
    chk("lossy_ch1", 32'(rx_cnt[1]), 32'd4);
    chk("lossy_ch1_last", 32'(rx_last[1]), 32'd0);
`ifdef AXIS_BCAST_STATS_EN
    i_stats_clr = 1'b1;
    cycles(1);
    i_stats_clr = 1'b0;
    cycles(1);
    chk("stats_clr", 32'(o_drop_count[31:16]), 32'd0);
`endif

    // Enable change mid-packet applies only from the next packet.
    i_mode = 1'b0; i_ch_enable = 4'b0011;
    clear_counts();
    push(4, 32'h100, 4); push(3, 32'h200, 3);
    cycles(2);
    i_ch_enable = 4'b0001;
    cycles(15);
    chk("en_ch0", 32'(rx_cnt[0]), 32'd7);
    chk("en_ch1", 32'(rx_cnt[1]), 32'd4);
    chk("en_ch1_last", 32'(rx_last[1]), 32'd1);

    // No channel enabled: beats accepted and discarded.
    i_ch_enable = 4'b0000;
    clear_counts();
    push(5, 32'h300, 5);
    cycles(10);
    chk("none_acc", 32'(acc_cnt), 32'd5);
    for (int c = 0; c < N; c++) chk($sformatf("none_ch%0d", c), 32'(rx_cnt[c]), 32'd0);

    // Single-beat packets on all channels.
    i_ch_enable = 4'b1111;
    clear_counts();
    push(16, 32'h400, 1);
    cycles(22);
    for (int c = 0; c < N; c++) begin
      chk($sformatf("single_ch%0d", c), 32'(rx_cnt[c]), 32'd16);
      chk($sformatf("single_last_ch%0d", c), 32'(rx_last[c]), 32'd16);
    end

    // Randomized traffic, readiness and configuration.
    for (int k = 0; k < 300; k++)
      src_q.push_back('{$urandom, (k == 299) || ($urandom_range(3) == 0)});
    cfg_rand = 1'b1; rdy_rand = 1'b1; vprob = 70;
    cycles(500);
    cfg_rand = 1'b0; rdy_rand = 1'b0; rdy_val = 4'b1111; i_mode = 1'b1; vprob = 100;
    cycles(40);
    chk("rand_drained", 32'(src_q.size()), 32'd0);

    // Asynchronous reset with full FIFOs mid-packet.
    i_mode = 1'b1; i_ch_enable = 4'b1111; rdy_val = 4'b0000;
    push(10, 32'h500, 0);
    cycles(8);
    chk("pre_rst_valid", 32'(m_axis_tvalid), 32'hf);
    @(posedge s_axi_aclk);
    #3 s_axi_aresetn = 1'b0;
    s_axis_tvalid = 1'b0;
    #1;
    chk("arst_tready", 32'(s_axis_tready), 32'h0);
    chk("arst_tvalid", 32'(m_axis_tvalid), 32'h0);
    chk("arst_tlast", 32'(m_axis_tlast), 32'h0);
    for (int c = 0; c < N; c++) chk("arst_tdata", m_axis_tdata[c*W +: W], 32'h0);
`ifdef AXIS_BCAST_STATS_EN
    chk("arst_drops", 32'(|o_drop_count), 32'h0);
`endif
    for (int c = 0; c < N; c++) begin
      mq[c].delete();
      m_drops[c] = 0;
    end
    src_q.delete();
    m_start = 1'b1;
    acc_q = 1'b0;
    repeat (2) @(posedge s_axi_aclk);
    #3 s_axi_aresetn = 1'b1;
    #1 chk("arst_release_tready", 32'(s_axis_tready), 32'h1);
    i_mode = 1'b0; i_ch_enable = 4'b0001; rdy_val = 4'b1111;
    clear_counts();
    push(2, 32'h600, 2);
    cycles(8);
    chk("after_rst_ch0", 32'(rx_cnt[0]), 32'd2);
    for (int c = 1; c < N; c++) chk($sformatf("after_rst_ch%0d", c), 32'(rx_cnt[c]), 32'd0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
